rr_grant_sequencer: RTL and testbench
=====================================

Name: rr_grant_sequencer

Overview:
- 16-requester round-robin arbiter that produces a 4-bit grant index plus an enable.
- Sits directly upstream of the 4-to-16 case decoder: grant_idx drives the decoder's in, grant_en drives its enable.
- The decoder's 16-bit output is therefore the one-hot grant vector.
- Adds grant holding, release by done, fairness pointer and a hold-timeout watchdog.

Parameters:
- NUM_REQ, 16, number of requesters; fixed at 16 to match the decoder width.
- IDX_W, 4, width of grant_idx.
- MAX_HOLD, 32, maximum cycles a grant may be held; 0 disables the timeout; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  16  request vector, bit i = requester i; level-sensitive.
- done  input  1  current grantee finished; sampled only in GRANT.
- grant_idx  output  4  index of the granted requester; holds last value when grant_en=0.
- grant_en  output  1  grant active; decoder enable.
- timeout  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD watchdog.
- busy  output  1  high while in GRANT (equals grant_en).

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset values: state=IDLE, ptr=0, grant_idx=0, grant_en=0, busy=0, timeout=0, hold_cnt=0.
- All outputs are registered.
- IDLE state:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit searching ptr, ptr+1, … wrapping 15→0 (ptr itself has highest priority).
  - Next edge: grant_idx=selected, grant_en=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled high at edge k gives grant_en=1 after edge k (visible in cycle k+1).
- GRANT state:
  - grant_idx is stable for the whole grant.
  - hold_cnt increments each cycle, saturating at 255.
  - Exit conditions, checked each edge:
    (a) done=1;
    (b) req[grant_idx]=0 (requester withdrew);
    (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, i.e. the grant lasted MAX_HOLD cycles.
  - On exit: grant_en=0, ptr=grant_idx+1 mod 16, return to IDLE. grant_idx keeps its value.
  - timeout=1 for one cycle only when exit is due solely to (c).
  - If (c) coincides with (a) or (b), it is a normal exit and timeout stays 0.
- Minimum one IDLE cycle between consecutive grants: grant_en drops low for at least one cycle, even if other requests are pending.
- Changes on req bits other than grant_idx during GRANT are ignored.
- Fairness: a continuously requesting line waits at most 15 other grants.
- ptr wrap: grant_idx=15 sets ptr=0.
- A single requester may be re-granted after the mandatory idle cycle if it is still the first set bit from ptr.
- done in IDLE is ignored.
- Reset mid-grant: outputs clear immediately (asynchronous), ptr returns to 0, and arbitration restarts from requester 0 after deassertion.
- rst_n deassertion is synchronised externally; no internal synchroniser.
- No combinational path from req or done to any output.

Test Plan:
- Reset then req=16'h0001: grant_en=1, grant_idx=0 one cycle later. Pulse done: grant_en=0 next cycle, ptr=1.
- req=16'h8001 held, done pulsed one cycle after each grant: grant_idx sequence 0,15,0,15, with a grant_en low cycle between each; timeout never asserts.
- ptr=5 (after granting 4), req=16'h0FFF: grant_idx=5. After done, 6, then 7, … 11, then wraps to 0.
- MAX_HOLD=4, req=16'h0008 held, done=0: grant_en high exactly 4 cycles, timeout=1 on the cycle grant_en falls, ptr=4.
  - Repeat with done=1 on the 4th cycle: timeout stays 0.
- Grant to idx 2, then req[2] drops mid-grant while req[9]=1: grant_en falls next edge, one idle cycle, then grant_idx=9.
- Assert rst_n=0 asynchronously mid-grant (idx 7): grant_en, grant_idx, busy clear without a clock edge. After release with req=16'h0080: grant_idx=7, ptr search starts at 0.

Source files
------------

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle for the round-robin grant sequencer.
// Requesters drive req/done; the sequencer drives the grant side.
interface rr_grant_sequencer_if #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4
);
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_en;
  logic               timeout;
  logic               busy;

  modport master (
    output req, done,
    input  grant_idx, grant_en, timeout, busy
  );

  modport slave (
    input  req, done,
    output grant_idx, grant_en, timeout, busy
  );
endinterface

// File: rtl/rr_grant_sequencer.sv
// 16-way round-robin arbiter with grant hold, done release,
// fairness pointer and hold-timeout watchdog.
module rr_grant_sequencer #(
  parameter int NUM_REQ  = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_grant_sequencer_if.slave   bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam bit HOLD_ON = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST =
    8'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [7:0]       hold_cnt;
  logic [IDX_W-1:0] sel;
  logic             found;
  logic             rel;
  logic             expire;

  // First set request at or after ptr, wrapping 15 -> 0.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[ptr + IDX_W'(i)]) begin
        sel   = ptr + IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // Release and watchdog conditions for the current grant.
  always_comb begin
    rel    = bus.done | ~bus.req[bus.grant_idx];
    expire = HOLD_ON && (hold_cnt == HOLD_LAST);
  end

  // Arbitration FSM; all outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      hold_cnt      <= '0;
      bus.grant_idx <= '0;
      bus.grant_en  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            bus.grant_idx <= sel;
            bus.grant_en  <= 1'b1;
            bus.busy      <= 1'b1;
            hold_cnt      <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (hold_cnt != 8'hFF)
            hold_cnt <= hold_cnt + 8'd1;
          if (rel || expire) begin
            bus.grant_en <= 1'b0;
            bus.busy     <= 1'b0;
            bus.timeout  <= expire & ~rel;
            ptr          <= bus.grant_idx + 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer.
// Uses a short watchdog (MAX_HOLD=4) so timeout paths are reachable.
module tb_rr_grant_sequencer;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  rr_grant_sequencer_if #(.NUM_REQ(16), .IDX_W(4)) bus ();

  rr_grant_sequencer #(
    .NUM_REQ (16),
    .IDX_W   (4),
    .MAX_HOLD(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [3:0] seq2 [4];
  logic [3:0] seq3 [8];

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    seq2 = '{4'd0, 4'd15, 4'd0, 4'd15};
    seq3 = '{4'd5, 4'd6, 4'd7, 4'd8,
             4'd9, 4'd10, 4'd11, 4'd0};

    tick();
    tick();
    check("rst_en",   16'(bus.grant_en), 16'd0);
    check("rst_idx",  16'(bus.grant_idx), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_to",   16'(bus.timeout), 16'd0);
    rst_n = 1'b1;
    tick();
    check("idle_en", 16'(bus.grant_en), 16'd0);

    // single requester, done release
    bus.req = 16'h0001;
    tick();
    check("t1_en",   16'(bus.grant_en), 16'd1);
    check("t1_idx",  16'(bus.grant_idx), 16'd0);
    check("t1_busy", 16'(bus.busy), 16'd1);
    bus.done = 1'b1;
    tick();
    check("t1_rel", 16'(bus.grant_en), 16'd0);
    check("t1_to",  16'(bus.timeout), 16'd0);
    check("t1_hold_idx", 16'(bus.grant_idx), 16'd0);
    bus.done = 1'b0;
    bus.req  = '0;
    tick();
    // ptr=1 now: bits 0 and 3 -> expect 3
    bus.req = 16'h0009;
    tick();
    check("t1_ptr", 16'(bus.grant_idx), 16'd3);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // alternating 0 / 15
    do_reset();
    bus.req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_en",  16'(bus.grant_en), 16'd1);
      check("t2_idx", 16'(bus.grant_idx), 16'(seq2[i]));
      check("t2_to",  16'(bus.timeout), 16'd0);
      bus.done = 1'b1;
      tick();
      check("t2_gap", 16'(bus.grant_en), 16'd0);
      check("t2_to",  16'(bus.timeout), 16'd0);
      bus.done = 1'b0;
    end
    bus.req = '0;

    // ptr=5 sweep with wrap
    do_reset();
    bus.req = 16'h0010;
    tick();
    check("t3_pre", 16'(bus.grant_idx), 16'd4);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 16'h0FFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t3_en",  16'(bus.grant_en), 16'd1);
      check("t3_idx", 16'(bus.grant_idx), 16'(seq3[i]));
      bus.done = 1'b1;
      tick();
      check("t3_gap", 16'(bus.grant_en), 16'd0);
      bus.done = 1'b0;
    end
    bus.req = '0;

    // watchdog timeout after 4 cycles
    do_reset();
    bus.req = 16'h0008;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_en",  16'(bus.grant_en), 16'd1);
      check("t4_idx", 16'(bus.grant_idx), 16'd3);
      check("t4_to",  16'(bus.timeout), 16'd0);
    end
    tick();
    check("t4_drop", 16'(bus.grant_en), 16'd0);
    check("t4_tout", 16'(bus.timeout), 16'd1);
    bus.req = 16'h0018;
    tick();
    check("t4_pulse", 16'(bus.timeout), 16'd0);
    check("t4_ptr",   16'(bus.grant_idx), 16'd4);
    check("t4_en2",   16'(bus.grant_en), 16'd1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // watchdog coinciding with done
    do_reset();
    bus.req = 16'h0008;
    for (int i = 0; i < 4; i++) tick();
    check("t5_en", 16'(bus.grant_en), 16'd1);
    bus.done = 1'b1;
    tick();
    check("t5_drop", 16'(bus.grant_en), 16'd0);
    check("t5_to",   16'(bus.timeout), 16'd0);
    bus.done = 1'b0;
    bus.req  = '0;
    tick();
    check("t5_to2", 16'(bus.timeout), 16'd0);

    // withdrawal mid-grant
    do_reset();
    bus.req = 16'h0204;
    tick();
    check("t6_idx", 16'(bus.grant_idx), 16'd2);
    tick();
    check("t6_hold", 16'(bus.grant_en), 16'd1);
    check("t6_stab", 16'(bus.grant_idx), 16'd2);
    bus.req = 16'h0200;
    tick();
    check("t6_drop", 16'(bus.grant_en), 16'd0);
    check("t6_to",   16'(bus.timeout), 16'd0);
    tick();
    check("t6_en2",  16'(bus.grant_en), 16'd1);
    check("t6_idx2", 16'(bus.grant_idx), 16'd9);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // async reset mid-grant with ptr moved to 8
    do_reset();
    bus.req = 16'h0080;
    tick();
    check("t7_idx", 16'(bus.grant_idx), 16'd7);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    tick();
    check("t7_regr", 16'(bus.grant_en), 16'd1);
    check("t7_idx2", 16'(bus.grant_idx), 16'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_aen",   16'(bus.grant_en), 16'd0);
    check("t7_aidx",  16'(bus.grant_idx), 16'd0);
    check("t7_abusy", 16'(bus.busy), 16'd0);
    bus.req = 16'h0880;
    tick();
    tick();
    check("t7_hold", 16'(bus.grant_en), 16'd0);
    rst_n = 1'b1;
    tick();
    check("t7_en3",  16'(bus.grant_en), 16'd1);
    check("t7_idx3", 16'(bus.grant_idx), 16'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
